xaddr_router: RTL and testbench

Parametrised, registered successor to the combinational address decoder. It routes one master access to one of `N_SLV` slave channels. Each channel has a base address and an offset width supplied as parameters. The block holds the slave select until the slave signals ready, with a wait-state timeout. It returns registered read data with a one-cycle `ready` pulse to the master, and records unmapped or timed-out accesses in a sticky trap register. It sits between the CPU data port and the peripheral set: memory, register file, switches, buttons, ALU, display.

---
 rtl/xaddr_router_pkg.sv | 35 +++
 rtl/xaddr_match.sv | 38 +++
 rtl/xaddr_router.sv | 148 ++++++++++++++
 tb/tb_xaddr_router.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xaddr_router_pkg.sv
// Shared definitions for the address router: FSM encoding, default widths and
// the peripheral address map used to build the router's base/offset vectors.
package xaddr_router_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;
    localparam int OFFS_FW    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Peripheral windows: base address and number of low offset bits.
    localparam logic [ADDR_W_DEF-1:0] MEM_BASE    = 13'h0000;
    localparam logic [OFFS_FW-1:0]    MEM_OFFS_W  = 5'd12;
    localparam logic [ADDR_W_DEF-1:0] REGF_BASE   = 13'h1000;
    localparam logic [OFFS_FW-1:0]    REGF_OFFS_W = 5'd4;
    localparam logic [ADDR_W_DEF-1:0] SW_BASE     = 13'h1010;
    localparam logic [OFFS_FW-1:0]    SW_OFFS_W   = 5'd0;
    localparam logic [ADDR_W_DEF-1:0] BTN_BASE    = 13'h1011;
    localparam logic [OFFS_FW-1:0]    BTN_OFFS_W  = 5'd0;
    localparam logic [ADDR_W_DEF-1:0] ALU_BASE    = 13'h1020;
    localparam logic [OFFS_FW-1:0]    ALU_OFFS_W  = 5'd3;
    localparam logic [ADDR_W_DEF-1:0] DISP_BASE   = 13'h1030;
    localparam logic [OFFS_FW-1:0]    DISP_OFFS_W = 5'd2;

    // Default four-channel map: memory, register file, switches, buttons.
    localparam logic [4*ADDR_W_DEF-1:0] DEF_SLV_BASE =
        {BTN_BASE, SW_BASE, REGF_BASE, MEM_BASE};
    localparam logic [4*OFFS_FW-1:0] DEF_SLV_OFFS_W =
        {BTN_OFFS_W, SW_OFFS_W, REGF_OFFS_W, MEM_OFFS_W};

endpackage

// File: rtl/xaddr_match.sv
// Combinational window decoder: reports whether addr falls in any channel
// window and, if so, the lowest matching channel index.
module xaddr_match
    import xaddr_router_pkg::*;
#(
    parameter int                          N_SLV      = 4,
    parameter int                          ADDR_W     = ADDR_W_DEF,
    parameter logic [N_SLV*ADDR_W-1:0]     SLV_BASE   = DEF_SLV_BASE,
    parameter logic [N_SLV*OFFS_FW-1:0]    SLV_OFFS_W = DEF_SLV_OFFS_W,
    localparam int                         IDX_W      = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    logic [ADDR_W-1:0] mask [N_SLV];

    // An offset width equal to ADDR_W yields an all-zero mask (whole space).
    for (genvar g = 0; g < N_SLV; g++) begin : g_mask
        localparam int              W    = int'(SLV_OFFS_W[g*OFFS_FW +: OFFS_FW]);
        localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(1) << W;
        assign mask[g] = ~(SPAN[ADDR_W-1:0] - ADDR_W'(1));
    end

    // Scan from the top so the lowest-index hit is the one that sticks.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr & mask[i]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/xaddr_router.sv
// Registered master-to-slave address router with wait-state timeout and a
// sticky trap record for unmapped or timed-out accesses.
module xaddr_router
    import xaddr_router_pkg::*;
#(
    parameter int                          N_SLV      = 4,
    parameter int                          ADDR_W     = ADDR_W_DEF,
    parameter int                          DATA_W     = DATA_W_DEF,
    parameter logic [N_SLV*ADDR_W-1:0]     SLV_BASE   = DEF_SLV_BASE,
    parameter logic [N_SLV*OFFS_FW-1:0]    SLV_OFFS_W = DEF_SLV_OFFS_W,
    parameter int                          TO_CYC     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       data_to_wr,
    output logic                    ready,
    output logic [DATA_W-1:0]       data_to_rd,
    output logic [N_SLV-1:0]        slv_sel,
    output logic                    slv_we,
    output logic [ADDR_W-1:0]       slv_addr,
    output logic [DATA_W-1:0]       slv_wdata,
    input  logic [N_SLV-1:0]        slv_ready,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata,
    output logic                    trap,
    output logic                    trap_to,
    output logic [ADDR_W-1:0]       trap_addr,
    input  logic                    trap_clr,
    output state_t                  state
);

    // Handshake: the master raises sel with stable addr/we/data_to_wr and
    // holds them until the single-cycle ready pulse; a slave is addressed
    // only while its slv_sel bit is high and completes by raising its
    // slv_ready bit in any cycle of that window (zero-wait allowed).

    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CNT_W = $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

    logic              m_hit;
    logic [IDX_W-1:0]  m_idx;
    logic [IDX_W-1:0]  lat_idx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sel_rdata;
    logic              trap_fire;
    logic              trap_is_to;
    logic [ADDR_W-1:0] trap_at;

    xaddr_match #(
        .N_SLV      (N_SLV),
        .ADDR_W     (ADDR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_OFFS_W (SLV_OFFS_W)
    ) u_match (
        .addr (addr),
        .hit  (m_hit),
        .idx  (m_idx)
    );

    assign sel_rdata = slv_rdata[lat_idx*DATA_W +: DATA_W];

    // Trap events are resolved on the edge that enters RESP so the trap
    // flag becomes visible in the same cycle as ready.
    always_comb begin
        trap_fire  = 1'b0;
        trap_is_to = 1'b0;
        trap_at    = slv_addr;
        if (state == ST_IDLE && sel && !m_hit) begin
            trap_fire = 1'b1;
            trap_at   = addr;
        end else if (state == ST_ACCESS && !slv_ready[lat_idx] && cnt == CNT_LAST) begin
            trap_fire  = 1'b1;
            trap_is_to = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ready      <= 1'b0;
            data_to_rd <= '0;
            slv_sel    <= '0;
            slv_we     <= 1'b0;
            slv_addr   <= '0;
            slv_wdata  <= '0;
            lat_idx    <= '0;
            cnt        <= '0;
            trap       <= 1'b0;
            trap_to    <= 1'b0;
            trap_addr  <= '0;
        end else begin
            ready <= 1'b0;

            if (trap_clr) begin
                trap      <= 1'b0;
                trap_to   <= 1'b0;
                trap_addr <= '0;
            end
            // A coincident clear lets the new trap replace the old record.
            if (trap_fire && (!trap || trap_clr)) begin
                trap      <= 1'b1;
                trap_to   <= trap_is_to;
                trap_addr <= trap_at;
            end

            case (state)
                ST_IDLE: begin
                    if (sel) begin
                        slv_addr  <= addr;
                        slv_we    <= we;
                        slv_wdata <= data_to_wr;
                        lat_idx   <= m_idx;
                        cnt       <= '0;
                        if (m_hit) begin
                            slv_sel <= N_SLV'(1) << m_idx;
                            state   <= ST_ACCESS;
                        end else begin
                            data_to_rd <= '0;
                            ready      <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (slv_ready[lat_idx]) begin
                        data_to_rd <= sel_rdata;
                        slv_sel    <= '0;
                        ready      <= 1'b1;
                        state      <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        data_to_rd <= '0;
                        slv_sel    <= '0;
                        ready      <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xaddr_router.sv
// Randomized and directed bench for xaddr_router against a transaction-level
// reference model of the address map, slave latency and trap record.
module tb_xaddr_router;
    import xaddr_router_pkg::*;

    localparam int N_SLV  = 4;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int TO_CYC = 16;
    localparam int NEVER  = 255;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                    sel = 1'b0;
    logic                    we = 1'b0;
    logic [ADDR_W-1:0]       addr = '0;
    logic [DATA_W-1:0]       data_to_wr = '0;
    logic                    ready;
    logic [DATA_W-1:0]       data_to_rd;
    logic [N_SLV-1:0]        slv_sel;
    logic                    slv_we;
    logic [ADDR_W-1:0]       slv_addr;
    logic [DATA_W-1:0]       slv_wdata;
    logic [N_SLV-1:0]        slv_ready;
    logic [N_SLV*DATA_W-1:0] slv_rdata;
    logic                    trap;
    logic                    trap_to;
    logic [ADDR_W-1:0]       trap_addr;
    logic                    trap_clr = 1'b0;
    state_t                  state;

    xaddr_router #(
        .N_SLV      (N_SLV),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SLV_BASE   ({13'h1011, 13'h1010, 13'h1000, 13'h0000}),
        .SLV_OFFS_W ({5'd0, 5'd0, 5'd4, 5'd12}),
        .TO_CYC     (TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .data_to_wr (data_to_wr),
        .ready      (ready),
        .data_to_rd (data_to_rd),
        .slv_sel    (slv_sel),
        .slv_we     (slv_we),
        .slv_addr   (slv_addr),
        .slv_wdata  (slv_wdata),
        .slv_ready  (slv_ready),
        .slv_rdata  (slv_rdata),
        .trap       (trap),
        .trap_to    (trap_to),
        .trap_addr  (trap_addr),
        .trap_clr   (trap_clr),
        .state      (state)
    );

    // slave models: ready after wait_k cycles of selection; unselected
    // channels show random ready noise
    int          wait_k [N_SLV] = '{0, 0, 0, 0};
    logic [31:0] rdata_cfg [N_SLV] = '{0, 0, 0, 0};
    int unsigned wcnt = 0;
    logic [N_SLV-1:0] noise = '0;

    always @(posedge clk) begin
        wcnt  <= (slv_sel != '0) ? wcnt + 1 : 0;
        noise <= N_SLV'($urandom);
    end

    always_comb begin
        for (int i = 0; i < N_SLV; i++) begin
            slv_ready[i] = slv_sel[i] ? (wcnt >= wait_k[i]) : noise[i];
            slv_rdata[i*DATA_W +: DATA_W] = rdata_cfg[i];
        end
    end

    // reference model: address map as byte ranges, trap record
    int ref_base [N_SLV] = '{'h0000, 'h1000, 'h1010, 'h1011};
    int ref_size [N_SLV] = '{4096, 16, 1, 1};
    bit                ref_trap = 0;
    bit                ref_trap_to = 0;
    logic [ADDR_W-1:0] ref_trap_addr = '0;

    function automatic int ref_decode(input int a);
        for (int i = 0; i < N_SLV; i++)
            if (a >= ref_base[i] && a < ref_base[i] + ref_size[i]) return i;
        return -1;
    endfunction

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_trap();
        check_eq("trap", 64'(trap), 64'(ref_trap));
        check_eq("trap_to", 64'(trap_to), 64'(ref_trap_to));
        check_eq("trap_addr", 64'(trap_addr), 64'(ref_trap_addr));
    endtask

    // driver: one access, caller positioned just after a clock edge
    task automatic do_access(input logic [ADDR_W-1:0] a, input logic w,
                             input logic [DATA_W-1:0] wd, input bit keep_sel,
                             input bit clr_with);
        int idx, exp_lat, exp_sel_cyc, cyc, sel_cyc;
        bit fault;
        logic [DATA_W-1:0] exp_data;
        logic [N_SLV-1:0]  exp_onehot;

        idx = ref_decode(int'(a));
        fault = 0;
        exp_onehot = '0;
        if (idx < 0) begin
            exp_lat = 1; exp_sel_cyc = 0; exp_data = '0; fault = 1;
        end else begin
            exp_onehot = N_SLV'(1) << idx;
            if (wait_k[idx] < TO_CYC) begin
                exp_lat = 2 + wait_k[idx]; exp_sel_cyc = wait_k[idx] + 1;
                exp_data = rdata_cfg[idx];
            end else begin
                exp_lat = 1 + TO_CYC; exp_sel_cyc = TO_CYC; exp_data = '0; fault = 1;
            end
        end
        if (clr_with) begin
            ref_trap = 0; ref_trap_to = 0; ref_trap_addr = '0;
        end
        if (fault && !ref_trap) begin
            ref_trap = 1; ref_trap_to = (idx >= 0); ref_trap_addr = a;
        end

        sel = 1'b1; addr = a; we = w; data_to_wr = wd; trap_clr = clr_with;
        cyc = 0; sel_cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            trap_clr = 1'b0;
            if (cyc == 1) addr = ADDR_W'($urandom);
            if (slv_sel != '0) begin
                sel_cyc++;
                check_eq("slv_sel", 64'(slv_sel), 64'(exp_onehot));
                check_eq("slv_we", 64'(slv_we), 64'(w));
                check_eq("slv_addr", 64'(slv_addr), 64'(a));
                check_eq("slv_wdata", 64'(slv_wdata), 64'(wd));
            end
            if (ready) break;
            if (cyc >= 40) begin
                check_eq("ready_wait_bound", 64'(cyc), 64'(exp_lat));
                break;
            end
        end
        check_eq("latency", 64'(cyc), 64'(exp_lat));
        check_eq("data_to_rd", 64'(data_to_rd), 64'(exp_data));
        check_eq("sel_cycles", 64'(sel_cyc), 64'(exp_sel_cyc));
        check_eq("slv_sel_resp", 64'(slv_sel), 64'(0));
        check_trap();
        if (!keep_sel) sel = 1'b0;
        @(posedge clk); #1;
        check_eq("ready_pulse", 64'(ready), 64'(0));
        check_eq("state_idle", 64'(state), 64'(ST_IDLE));
    endtask

    task automatic pulse_clr();
        sel = 1'b0;
        trap_clr = 1'b1;
        @(posedge clk); #1;
        trap_clr = 1'b0;
        ref_trap = 0; ref_trap_to = 0; ref_trap_addr = '0;
        check_trap();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", 64'(state), 64'(ST_IDLE));
        check_eq("rst_ready", 64'(ready), 64'(0));
        check_eq("rst_slv_sel", 64'(slv_sel), 64'(0));
        check_eq("rst_slv_we", 64'(slv_we), 64'(0));
        check_eq("rst_slv_addr", 64'(slv_addr), 64'(0));
        check_eq("rst_slv_wdata", 64'(slv_wdata), 64'(0));
        check_eq("rst_data_to_rd", 64'(data_to_rd), 64'(0));
        check_trap();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // directed cases
        wait_k    = '{0, 3, NEVER, 0};
        rdata_cfg = '{32'hDEADBEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_C0DE};
        do_access(13'h0ABC, 1'b0, 32'h0, 0, 0);
        do_access(13'h1005, 1'b1, 32'h55, 0, 0);
        do_access(13'h1FFF, 1'b0, 32'h0, 0, 0);
        pulse_clr();
        do_access(13'h1010, 1'b0, 32'h0, 0, 0);
        do_access(13'h1FFF, 1'b0, 32'h0, 0, 0);
        pulse_clr();
        do_access(13'h1FFF, 1'b0, 32'h0, 0, 0);
        do_access(13'h1234, 1'b0, 32'h0, 0, 1);
        do_access(13'h0000, 1'b0, 32'h0, 1, 0);
        do_access(13'h1011, 1'b1, 32'hA5A5, 0, 0);

        // reset during ACCESS
        sel = 1'b1; addr = 13'h1010; we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_slv_sel", 64'(slv_sel), 64'(4'b0100));
        rst = 1'b1;
        sel = 1'b0;
        #1;
        ref_trap = 0; ref_trap_to = 0; ref_trap_addr = '0;
        check_eq("mid_rst_slv_sel", 64'(slv_sel), 64'(0));
        check_eq("mid_rst_ready", 64'(ready), 64'(0));
        check_eq("mid_rst_state", 64'(state), 64'(ST_IDLE));
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("post_rst_no_ready", 64'(ready), 64'(0));
        end
        do_access(13'h0ABC, 1'b0, 32'h0, 0, 0);

        // randomized accesses
        for (int n = 0; n < 60; n++) begin
            logic [ADDR_W-1:0] a;
            for (int i = 0; i < N_SLV; i++) begin
                wait_k[i]    = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 4));
                rdata_cfg[i] = $urandom;
            end
            case ($urandom_range(0, 2))
                0:       a = ADDR_W'($urandom);
                1:       a = ADDR_W'(13'h1000 + $urandom_range(0, 31));
                default: a = ADDR_W'($urandom_range(0, 4095));
            endcase
            if ($urandom_range(0, 5) == 0) pulse_clr();
            do_access(a, 1'($urandom), $urandom, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 7) == 0);
        end
        sel = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
